nonce_search_ctrl: RTL and testbench

//  Initiator side of the SHA computational block interface. Builds each 440-bit message from a header

---
 rtl/sha_miner_pkg.sv | 18 +
 rtl/digest_target_cmp.sv | 21 ++
 rtl/nonce_search_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_nonce_search_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_miner_pkg.sv
// Shared widths and FSM state encoding for the nonce search controller.
package sha_miner_pkg;

  localparam int MSG_W    = 440;
  localparam int DIGEST_W = 256;
  localparam int PREFIX_W = 408;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    LAUNCH2,
    WAIT2,
    CHECK,
    FIN
  } state_t;

endpackage

// File: rtl/digest_target_cmp.sv
// Registered unsigned digest < target compare, loaded on the digest capture strobe.
module digest_target_cmp
  import sha_miner_pkg::*;
(
  input  logic                clk,
  input  logic                n_rst,
  input  logic                en,
  input  logic [DIGEST_W-1:0] digest,
  input  logic [DIGEST_W-1:0] target,
  output logic                lt
);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      lt <= 1'b0;
    end else if (en) begin
      lt <= (digest < target);
    end
  end

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce search initiator driving one SHA computational block.
// Build option DOUBLE_SHA_EN: each nonce is hashed twice, the second pass over {184'd0, digest1}.
module nonce_search_ctrl
  import sha_miner_pkg::*;
#(
  parameter int SHA_TIMEOUT = 256,
  parameter int NONCE_W     = 32
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [PREFIX_W-1:0] msg_prefix,
  input  logic [NONCE_W-1:0]  nonce_start,
  input  logic [NONCE_W-1:0]  nonce_end,
  input  logic [DIGEST_W-1:0] target,
  output logic [MSG_W-1:0]    sha_msg,
  output logic                sha_begin,
  input  logic                sha_complete,
  input  logic [DIGEST_W-1:0] sha_digest,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic                timeout_err,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [DIGEST_W-1:0] found_hash
);

  // state   | meaning
  // IDLE    | waiting for start
  // LAUNCH  | sha_begin pulse with {prefix, nonce}
  // WAIT    | waiting for sha_complete, first cycle ignored
  // LAUNCH2 | second-pass launch over digest1 (DOUBLE_SHA_EN)
  // WAIT2   | second-pass wait (DOUBLE_SHA_EN)
  // CHECK   | compare result valid: hit, advance or finish
  // FIN     | one-cycle done pulse

  localparam int WD_W = $clog2(SHA_TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [PREFIX_W-1:0] prefix_q;
  logic [NONCE_W-1:0]  nonce_q;
  logic [NONCE_W-1:0]  end_q;
  logic [NONCE_W-1:0]  nonce_nxt;
  logic [DIGEST_W-1:0] target_q;
  logic [DIGEST_W-1:0] digest_q;
  logic [WD_W-1:0]     wdog_q;
  logic                ld_job;
  logic                ld_next;
  logic                ld_msg2;
  logic                cap;
  logic                hit;
  logic                to_err;
  logic                wait_ok;
  logic                wait_to;
  logic                lt;

  assign nonce_nxt = nonce_q + 1'b1;

  // wdog is zero only on the first wait cycle, where sha_complete is still the previous hash's level
  assign wait_ok = (wdog_q != '0) && sha_complete;
  assign wait_to = (wdog_q == WD_W'(SHA_TIMEOUT));

  assign sha_begin = ((state_q == LAUNCH) || (state_q == LAUNCH2)) && !abort;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN) && !abort;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ld_job  = 1'b0;
    ld_next = 1'b0;
    ld_msg2 = 1'b0;
    cap     = 1'b0;
    hit     = 1'b0;
    to_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ld_job  = 1'b1;
          state_d = (nonce_start > nonce_end) ? FIN : LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (wait_ok) begin
          cap = 1'b1;
`ifdef DOUBLE_SHA_EN
          ld_msg2 = 1'b1;
          state_d = LAUNCH2;
`else
          state_d = CHECK;
`endif
        end else if (wait_to) begin
          to_err  = 1'b1;
          state_d = FIN;
        end
      end
`ifdef DOUBLE_SHA_EN
      LAUNCH2: state_d = WAIT2;
      WAIT2: begin
        if (wait_ok) begin
          cap     = 1'b1;
          state_d = CHECK;
        end else if (wait_to) begin
          to_err  = 1'b1;
          state_d = FIN;
        end
      end
`endif
      CHECK: begin
        if (lt) begin
          hit     = 1'b1;
          state_d = FIN;
        end else if (nonce_q == end_q) begin
          state_d = FIN;
        end else begin
          ld_next = 1'b1;
          state_d = LAUNCH;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      ld_job  = 1'b0;
      ld_next = 1'b0;
      ld_msg2 = 1'b0;
      cap     = 1'b0;
      hit     = 1'b0;
      to_err  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      prefix_q    <= '0;
      nonce_q     <= '0;
      end_q       <= '0;
      target_q    <= '0;
      digest_q    <= '0;
      wdog_q      <= '0;
      sha_msg     <= '0;
      found       <= 1'b0;
      timeout_err <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
    end else begin
      if ((state_q == LAUNCH) || (state_q == LAUNCH2)) begin
        wdog_q <= '0;
      end else if ((state_q == WAIT) || (state_q == WAIT2)) begin
        wdog_q <= wdog_q + 1'b1;
      end

      if (ld_job) begin
        prefix_q    <= msg_prefix;
        nonce_q     <= nonce_start;
        end_q       <= nonce_end;
        target_q    <= target;
        sha_msg     <= {msg_prefix, nonce_start};
        found       <= 1'b0;
        timeout_err <= 1'b0;
        found_nonce <= '0;
        found_hash  <= '0;
      end

      if (ld_next) begin
        nonce_q <= nonce_nxt;
        sha_msg <= {prefix_q, nonce_nxt};
      end

      if (ld_msg2) begin
        sha_msg <= {{(MSG_W-DIGEST_W){1'b0}}, sha_digest};
      end

      if (cap) begin
        digest_q <= sha_digest;
      end

      if (to_err) begin
        timeout_err <= 1'b1;
      end

      if (hit) begin
        found       <= 1'b1;
        found_nonce <= nonce_q;
        found_hash  <= digest_q;
      end
    end
  end

  digest_target_cmp u_cmp (
    .clk    (clk),
    .n_rst  (n_rst),
    .en     (cap),
    .digest (sha_digest),
    .target (target_q),
    .lt     (lt)
  );

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl with a behavioural SHA block of programmable latency and digest.
module tb_nonce_search_ctrl;
  import sha_miner_pkg::*;

  localparam int TO = 256;

  logic                clk = 1'b0;
  logic                n_rst = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [PREFIX_W-1:0] msg_prefix = '0;
  logic [31:0]         nonce_start = '0;
  logic [31:0]         nonce_end = '0;
  logic [DIGEST_W-1:0] target = '0;
  logic [MSG_W-1:0]    sha_msg;
  logic                sha_begin;
  logic                sha_complete;
  logic [DIGEST_W-1:0] sha_digest;
  logic                busy, done, found, timeout_err;
  logic [31:0]         found_nonce;
  logic [DIGEST_W-1:0] found_hash;

  nonce_search_ctrl #(.SHA_TIMEOUT(TO), .NONCE_W(32)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .abort        (abort),
    .msg_prefix   (msg_prefix),
    .nonce_start  (nonce_start),
    .nonce_end    (nonce_end),
    .target       (target),
    .sha_msg      (sha_msg),
    .sha_begin    (sha_begin),
    .sha_complete (sha_complete),
    .sha_digest   (sha_digest),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .timeout_err  (timeout_err),
    .found_nonce  (found_nonce),
    .found_hash   (found_hash)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;

  // SHA model knobs
  int                  lat = 4;
  bit                  hang = 1'b0;
  bit                  hit_en = 1'b0;
  bit                  dbl_chk = 1'b0;
  logic [31:0]         hit_nonce = '0;
  logic [DIGEST_W-1:0] hit_digest = '0;
  logic [DIGEST_W-1:0] base_digest = '0;
  logic [DIGEST_W-1:0] dbl_key = '0;

  int                  cnt = 0;
  logic                cmpl;
  logic [DIGEST_W-1:0] dig;
  logic [MSG_W-1:0]    msg_l;

  assign sha_complete = cmpl;
  assign sha_digest   = dig;

  function automatic logic [DIGEST_W-1:0] model(input logic [MSG_W-1:0] m);
    if (dbl_chk && (m[MSG_W-1:DIGEST_W] == '0)) return m[DIGEST_W-1:0] ^ dbl_key;
    if (hit_en && (m[31:0] == hit_nonce)) return hit_digest;
    return base_digest;
  endfunction

  // complete stays high (stale) for one cycle after a new begin, then drops until the result
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!n_rst) begin
      cmpl <= 1'b0;
      cnt  <= 0;
      dig  <= '0;
    end else if (sha_begin) begin
      cnt   <= lat;
      msg_l <= sha_msg;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == lat) cmpl <= 1'b0;
      if ((cnt == 1) && !hang) begin
        cmpl <= 1'b1;
        dig  <= model(msg_l);
      end
    end
  end

  typedef struct {
    int               c;
    logic [MSG_W-1:0] m;
  } launch_t;

  launch_t act_l[$];
  int      done_cyc[$];

  always @(negedge clk) begin
    if (sha_begin) act_l.push_back('{cyc, sha_msg});
    if (done) done_cyc.push_back(cyc);
  end

  task automatic kick(input logic [PREFIX_W-1:0] p, input logic [31:0] ns, input logic [31:0] ne,
                      input logic [DIGEST_W-1:0] t);
    act_l.delete();
    done_cyc.delete();
    @(negedge clk);
    msg_prefix  = p;
    nonce_start = ns;
    nonce_end   = ne;
    target      = t;
    start       = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; (i < budget) && !ok; i++) begin
      @(posedge clk);
      if (done_cyc.size() != 0) ok = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({busy, done, sha_begin} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: busy/done/begin=%b want 000", {busy, done, sha_begin}); end
    n_cmp++; if ({found, timeout_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: found/to=%b want 00", {found, timeout_err}); end
    n_cmp++; if (sha_msg !== '0) begin n_fail++; $display("FAIL reset_msg: got %h want 0", sha_msg); end
    n_cmp++; if ((found_nonce !== '0) || (found_hash !== '0)) begin n_fail++; $display("FAIL reset_found: nonce=%h hash=%h want 0", found_nonce, found_hash); end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_search(input string name, input logic [PREFIX_W-1:0] p, input logic [31:0] ns,
                             input logic [31:0] ne, input logic [DIGEST_W-1:0] t);
    logic [MSG_W-1:0]    em[$];
    logic [MSG_W-1:0]    e;
    logic [DIGEST_W-1:0] d;
    bit                  ef;
    logic [31:0]         en;
    logic [DIGEST_W-1:0] eh;
    bit                  ok;
    int                  nl;
    int                  prev_c;
    launch_t             a;
    ef = 1'b0; en = '0; eh = '0;
    for (longint n = longint'(ns); (n <= longint'(ne)) && !ef; n++) begin
      em.push_back({p, n[31:0]});
      d = model({p, n[31:0]});
`ifdef DOUBLE_SHA_EN
      em.push_back({{(MSG_W-DIGEST_W){1'b0}}, d});
      d = model({{(MSG_W-DIGEST_W){1'b0}}, d});
`endif
      if (d < t) begin ef = 1'b1; en = n[31:0]; eh = d; end
    end
    nl = em.size();
    kick(p, ns, ne, t);
    wait_done(nl * (lat + 3) + 40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL %s done: not seen, want pulse", name); end
    n_cmp++; if ((found !== ef) || (timeout_err !== 1'b0)) begin n_fail++; $display("FAIL %s found: found=%b to=%b want %b 0", name, found, timeout_err, ef); end
    n_cmp++; if (found_nonce !== en) begin n_fail++; $display("FAIL %s found_nonce: got %h want %h", name, found_nonce, en); end
    n_cmp++; if (found_hash !== eh) begin n_fail++; $display("FAIL %s found_hash: got %h want %h", name, found_hash, eh); end
    if (ns > ne) begin
      n_cmp++;
      if ((done_cyc.size() == 0) || (done_cyc[0] - start_cyc < 1) || (done_cyc[0] - start_cyc > 2)) begin
        n_fail++; $display("FAIL %s empty_latency: done not 1..2 cycles after start (seen %0d)", name, done_cyc.size());
      end
    end
    repeat (lat + 6) @(posedge clk);
    #1;
    n_cmp++; if (act_l.size() != nl) begin n_fail++; $display("FAIL %s launches: got %0d want %0d", name, act_l.size(), nl); end
    n_cmp++; if ((done_cyc.size() != 1) || (busy !== 1'b0)) begin n_fail++; $display("FAIL %s done_count: got %0d busy=%b want 1 0", name, done_cyc.size(), busy); end
    prev_c = 0;
    for (int i = 0; (act_l.size() != 0) && (em.size() != 0); i++) begin
      a = act_l.pop_front();
      e = em.pop_front();
      n_cmp++; if (a.m !== e) begin n_fail++; $display("FAIL %s msg%0d: got %h want %h", name, i, a.m, e); end
      if (i > 0) begin
        n_cmp++; if (a.c - prev_c != lat + 3) begin n_fail++; $display("FAIL %s spacing%0d: got %0d want %0d", name, i, a.c - prev_c, lat + 3); end
      end
      prev_c = a.c;
    end
  endtask

  task automatic test_timeout_abort();
    bit ok;
    hang = 1'b1;
    kick({51{8'h5A}}, 32'h100, 32'h100, '1);
    wait_done(TO + 40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL timeout done: not seen, want pulse"); end
    n_cmp++; if ((timeout_err !== 1'b1) || (found !== 1'b0)) begin n_fail++; $display("FAIL timeout flags: to=%b found=%b want 1 0", timeout_err, found); end
    n_cmp++;
    if ((act_l.size() != 1) || (done_cyc.size() == 0)) begin
      n_fail++; $display("FAIL timeout launch: launches=%0d dones=%0d want 1 1", act_l.size(), done_cyc.size());
    end else if ((done_cyc[0] - act_l[0].c < TO) || (done_cyc[0] - act_l[0].c > TO + 3)) begin
      n_fail++; $display("FAIL timeout latency: got %0d want %0d..%0d", done_cyc[0] - act_l[0].c, TO, TO + 3);
    end

    kick({51{8'h5A}}, 32'd0, 32'd10, '1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b want 0", busy); end
    repeat (TO + 10) @(posedge clk);
    #1;
    n_cmp++; if ((done_cyc.size() != 0) || (act_l.size() != 1)) begin n_fail++; $display("FAIL abort quiet: dones=%0d launches=%0d want 0 1", done_cyc.size(), act_l.size()); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL abort to_err: got %b want 0", timeout_err); end

    hang = 1'b0;
    base_digest = {8{32'h0BAD_F00D}};
    kick({51{8'h5A}}, 32'd2, 32'd2, '1);
    wait_done(60, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL restart done: not seen, want pulse"); end
    n_cmp++; if ((found !== 1'b1) || (found_nonce !== 32'd2)) begin n_fail++; $display("FAIL restart found: found=%b nonce=%h want 1 2", found, found_nonce); end
  endtask

  task automatic test_double_reset();
`ifdef DOUBLE_SHA_EN
    dbl_chk     = 1'b1;
    base_digest = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
    dbl_key     = {8{32'h0F0F_0F0F}};
    test_search("double", {51{8'hA5}}, 32'd9, 32'd9, '1);
    dbl_chk = 1'b0;
`endif
    hang = 1'b1;
    kick({51{8'hA5}}, 32'd0, 32'd5, '1);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid busy_before: got %b want 1", busy); end
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if ({busy, done, sha_begin, found, timeout_err} !== 5'b0) begin n_fail++; $display("FAIL rst_mid ctl: got %b want 00000", {busy, done, sha_begin, found, timeout_err}); end
    n_cmp++; if ((sha_msg !== '0) || (found_nonce !== '0) || (found_hash !== '0)) begin n_fail++; $display("FAIL rst_mid data: msg=%h nonce=%h", sha_msg, found_nonce); end
    @(negedge clk);
    n_rst = 1'b1;
    hang  = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if ((done_cyc.size() != 0) || (busy !== 1'b0)) begin n_fail++; $display("FAIL rst_mid after: dones=%0d busy=%b want 0 0", done_cyc.size(), busy); end
  endtask

  initial begin
    logic [DIGEST_W-1:0] tgt;
    test_reset();

    lat = 4;
    base_digest = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
    test_search("single_hit", '0, 32'd5, 32'd5, '1);

    lat = 6;
    test_search("range_miss", '0, 32'd0, 32'd3, '0);

    lat = 3;
    hit_en      = 1'b1;
    hit_nonce   = 32'd13;
    hit_digest  = 256'd13;
    base_digest = '1;
    tgt         = 256'd1 << 200;
    test_search("mid_hit", {51{8'h3C}}, 32'd10, 32'd20, tgt);

    hit_en      = 1'b0;
    base_digest = {8{32'h1357_9BDF}};
    test_search("wrap_end", '0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0);
    test_search("empty_range", '0, 32'd7, 32'd3, '1);

    test_timeout_abort();
    test_double_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
